// File: rtl/nn_ctrl_pkg.sv
// nn_ctrl_pkg -- shared types and defaults for the training-loop controller.
//   nn_state_t   : sequencer state encoding (ST_IDLE .. ST_DONE)
//   *_DEF        : default parameter values for nn_train_sequencer
//   IDX_W        : width of the neuron index and of the dwell timer
package nn_ctrl_pkg;

    localparam int N_HIDDEN_DEF = 8;
    localparam int FWD_LAT_DEF  = 3;
    localparam int OUT_LAT_DEF  = 2;
    localparam int EPOCH_W_DEF  = 8;
    localparam int LOSS_W_DEF   = 46;
    localparam int IDX_W        = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_INIT,
        ST_FWD,
        ST_OUT,
        ST_LOSS,
        ST_UPD,
        ST_CHECK,
        ST_DONE
    } nn_state_t;

endpackage

// File: rtl/nn_lat_timer.sv
// nn_lat_timer -- loadable down-counter used for the FWD/OUT/UPD dwell times.
//   clk_i       in  clock
//   rst_i       in  asynchronous reset, active low
//   load_i      in  load load_val_i this cycle (wins over counting)
//   load_val_i  in  dwell length minus one
//   zero_o      out count has reached zero (last cycle of the dwell)
module nn_lat_timer #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/nn_train_sequencer.sv
// nn_train_sequencer -- training-loop controller for the 8-hidden/1-output
// neuron datapath: initial weight load, forward pass, loss capture and
// per-neuron weight update, repeated for a programmed number of epochs.
//   clk_i, rst_i        clock / asynchronous active-low reset
//   start_i, epochs_i   start request (IDLE only) and epoch count
//   loss_i              loss from the output neuron
//   loss_thresh_i       early-stop threshold (NN_SEQ_EARLY_STOP_EN only)
//   hid_en_o, out_en_o  hidden-layer / output-neuron enables
//   w_sel_o, w_upd_o    weight-source mux and weight latch strobe
//   upd_idx_o           neuron being updated (N_HIDDEN = output neuron)
//   loss_q_o, epoch_o   captured loss, completed-epoch count
//   busy_o, done_o      activity flag, one-cycle completion pulse
//   stopped_o           early-stop flag
// Optional feature macro: NN_SEQ_EARLY_STOP_EN
//
// state        | meaning
// ST_IDLE      | waiting for start_i
// ST_LOAD_INIT | load initial weights into every neuron (1 cycle)
// ST_FWD       | hidden layer evaluating (FWD_LAT cycles)
// ST_OUT       | output neuron evaluating (OUT_LAT cycles)
// ST_LOSS      | capture loss_i (1 cycle)
// ST_UPD       | strobe back-pass weights into neurons 0..N_HIDDEN
// ST_CHECK     | count the epoch, decide FWD or DONE (1 cycle)
// ST_DONE      | done_o pulse (1 cycle)
module nn_train_sequencer
    import nn_ctrl_pkg::*;
#(
    parameter int N_HIDDEN = N_HIDDEN_DEF,
    parameter int FWD_LAT  = FWD_LAT_DEF,
    parameter int OUT_LAT  = OUT_LAT_DEF,
    parameter int EPOCH_W  = EPOCH_W_DEF,
    parameter int LOSS_W   = LOSS_W_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [EPOCH_W-1:0] epochs_i,
    input  logic [LOSS_W-1:0]  loss_i,
    input  logic [LOSS_W-1:0]  loss_thresh_i,
    output logic               hid_en_o,
    output logic               out_en_o,
    output logic               w_sel_o,
    output logic               w_upd_o,
    output logic [IDX_W-1:0]   upd_idx_o,
    output logic [LOSS_W-1:0]  loss_q_o,
    output logic [EPOCH_W-1:0] epoch_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               stopped_o
);

    nn_state_t          state_q, state_d;
    logic               tmr_load, tmr_zero;
    logic [IDX_W-1:0]   tmr_val;
    logic [EPOCH_W-1:0] epochs_q, epoch_next;
    logic [IDX_W-1:0]   idx_q;
    logic [LOSS_W-1:0]  loss_q;
    logic [EPOCH_W-1:0] epoch_q;
    logic               stopped_q, stop_hit, last_epoch;

    nn_lat_timer #(.W(IDX_W)) u_dwell (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    assign epoch_next = epoch_q + EPOCH_W'(1);
    // Equality stop: the count never passes epochs_q, so no saturation logic.
    assign last_epoch = (epoch_next == epochs_q);

`ifdef NN_SEQ_EARLY_STOP_EN
    assign stop_hit = (loss_q < loss_thresh_i);
`else
    logic unused_thresh;
    assign unused_thresh = ^loss_thresh_i;
    assign stop_hit      = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_LOAD_INIT;
            end
            ST_LOAD_INIT: begin
                if (epochs_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    state_d  = ST_FWD;
                    tmr_load = 1'b1;
                    tmr_val  = IDX_W'(FWD_LAT - 1);
                end
            end
            ST_FWD: begin
                if (tmr_zero) begin
                    state_d  = ST_OUT;
                    tmr_load = 1'b1;
                    tmr_val  = IDX_W'(OUT_LAT - 1);
                end
            end
            ST_OUT: begin
                if (tmr_zero) state_d = ST_LOSS;
            end
            ST_LOSS: begin
                state_d  = ST_UPD;
                tmr_load = 1'b1;
                tmr_val  = IDX_W'(N_HIDDEN);
            end
            ST_UPD: begin
                if (tmr_zero) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (last_epoch || stop_hit) begin
                    state_d = ST_DONE;
                end else begin
                    state_d  = ST_FWD;
                    tmr_load = 1'b1;
                    tmr_val  = IDX_W'(FWD_LAT - 1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath registers. upd_idx is staged one cycle ahead so it is valid
    // in the same cycle as the w_upd_o strobe, then holds its last value.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            epochs_q  <= '0;
            epoch_q   <= '0;
            idx_q     <= '0;
            loss_q    <= '0;
            stopped_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        epochs_q  <= epochs_i;
                        epoch_q   <= '0;
                        stopped_q <= 1'b0;
                        idx_q     <= IDX_W'(N_HIDDEN);
                    end
                end
                ST_LOSS: begin
                    loss_q <= loss_i;
                    idx_q  <= '0;
                end
                ST_UPD: begin
                    if (!tmr_zero) idx_q <= idx_q + IDX_W'(1);
                end
                ST_CHECK: begin
                    epoch_q <= epoch_next;
                    if (stop_hit) stopped_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign hid_en_o  = (state_q == ST_FWD);
    assign out_en_o  = (state_q == ST_OUT);
    assign w_sel_o   = (state_q != ST_IDLE) && (state_q != ST_LOAD_INIT);
    assign w_upd_o   = (state_q == ST_LOAD_INIT) || (state_q == ST_UPD);
    assign upd_idx_o = idx_q;
    assign loss_q_o  = loss_q;
    assign epoch_o   = epoch_q;
    assign busy_o    = (state_q != ST_IDLE);
    assign done_o    = (state_q == ST_DONE);
    assign stopped_o = stopped_q;

endmodule
